spi_rx_deserializer: RTL

//  Receive-side stage that sits beside the SPI TX serializer, downstream of the rx pin and upstream of the RX FIFO.

---
 rtl/spi_rx_deserializer_pkg.sv | 22 ++
 rtl/spi_rx_deserializer_edge_detect.sv | 28 ++
 rtl/spi_rx_deserializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_rx_deserializer_pkg.sv
// rtl/spi_rx_deserializer_pkg.sv - shared SPI register map, FSM encodings and bit positions
package spi_rx_deserializer_pkg;

    localparam logic [3:0] ADDR_DATA    = 4'h0;
    localparam logic [3:0] ADDR_STATUS  = 4'h4;
    localparam logic [3:0] ADDR_CONTROL = 4'h8;
    localparam logic [3:0] ADDR_BRD     = 4'hC;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam int CTRL_ENABLE_BIT   = 15;
    localparam int CTRL_CS_AUTO_BIT  = 5;
    localparam int CTRL_WORD_LEN_MSB = 4;
    localparam int CTRL_WORD_LEN_LSB = 0;

    localparam int STAT_RXFO_BIT = 0;
    localparam int STAT_RXFF_BIT = 1;
    localparam int STAT_RXFE_BIT = 2;

endpackage

// File: rtl/spi_rx_deserializer_edge_detect.sv
// rtl/spi_rx_deserializer_edge_detect.sv - one-cycle pulse on a rising or falling level transition
module spi_rx_deserializer_edge_detect #(
    parameter bit POSITIVE_EDGE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic pulse
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign pulse = POSITIVE_EDGE ? (~sig_q & sig_in) : (sig_q & ~sig_in);

endmodule

// File: rtl/spi_rx_deserializer.sv
// rtl/spi_rx_deserializer.sv - samples rx on baud falls, assembles MSB-first words, holds one for the RX FIFO
module spi_rx_deserializer
    import spi_rx_deserializer_pkg::*;
#(
    parameter int M           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         baud_in,
    input  logic         frame_active,
    input  logic [4:0]   word_len,
    input  logic         rx,
    output logic [M-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    input  logic         ov_clear,
    output logic         ovf,
    output logic [1:0]   state_dbg
);

    logic                   fall;
    logic                   rx_s;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [4:0]   len_q, len_d;
    logic [M-1:0] shreg_q, shreg_d;

    logic [M-1:0] rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         ovf_q, ovf_d;

    logic [5:0] cnt_inc;
    logic [5:0] len_bits;
    logic       done;

    spi_rx_deserializer_edge_detect #(
        .POSITIVE_EDGE(1'b0)
    ) u_baud_fall (
        .clk    (clk),
        .reset  (reset),
        .sig_in (baud_in),
        .pulse  (fall)
    );

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign cnt_inc  = cnt_q + 6'd1;
    assign len_bits = {1'b0, len_q} + 6'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        shreg_d = shreg_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    if (frame_active) begin
                        state_d = ST_SHIFT;
                        len_d   = word_len;
                    end
                end
                ST_SHIFT: begin
                    // A frame ending mid-word discards the partial word outright.
                    if (!frame_active) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end else if (fall) begin
                        shreg_d = {shreg_q[M-2:0], rx_s};
                        cnt_d   = cnt_inc;
                        if (cnt_inc == len_bits) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = frame_active ? ST_SHIFT : ST_IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shreg_q <= shreg_d;
        end
    end

    assign done = (state_q == ST_DONE);

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovf_d      = ovf_q;
        if (ov_clear) begin
            ovf_d = 1'b0;
        end
        // A word finishing while the FIFO takes the held one simply replaces it.
        if (done && (!rx_valid_q || rx_ready)) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
        end else if (done) begin
            ovf_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule
